// File: rtl/a2_bcd_conv.sv
// Binary word (signed or unsigned) to sign + packed BCD magnitude, using iterative double-dabble.
// Latency: a word accepted at edge N produces out_valid after edge N+DW. Minimum issue interval is DW+2 cycles.
// Backpressure: one conversion is in flight at a time. in_ready is high only in IDLE, and DONE holds while out_ready=0.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_signed (input handshake);
//        out_valid/out_ready/out_sign/out_bcd (result handshake, digit 0 in out_bcd[3:0]); busy (SHIFT or DONE).
module a2_bcd_conv #(
    parameter int DW     = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DW + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Reject parameterisations where the digit count cannot hold every magnitude.
    if (DW < 2) begin : g_dw_too_small
        $error("a2_bcd_conv: DW must be at least 2");
    end
    if (pow10(DIGITS) < (longint'(1) << DW)) begin : g_digits_too_few
        $error("a2_bcd_conv: 10**DIGITS must be >= 2**DW");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   mag;
    logic [BW-1:0]   bcd;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic            out_sign_r;
    logic [BW-1:0]   out_bcd_r;

    logic            in_neg;
    logic [DW-1:0]   in_mag;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_next;

    // The sign bit is the top bit of the word. Negating the most-negative value
    // wraps to 2^(DW-1), which is still the correct unsigned magnitude.
    assign in_neg = in_signed & in_data[DW-1];
    assign in_mag = in_neg ? ((~in_data) + {{(DW-1){1'b0}}, 1'b1}) : in_data;

    // Apply add-3 to each digit independently. Carries never cross digit boundaries.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BW-2:0], mag[DW-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mag        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            neg        <= 1'b0;
            out_sign_r <= 1'b0;
            out_bcd_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        neg   <= in_neg;
                        mag   <= in_mag;
                        bcd   <= '0;
                        cnt   <= CW'(DW);
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd <= bcd_next;
                    mag <= {mag[DW-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state      <= S_DONE;
                        out_bcd_r  <= bcd_next;
                        // A zero magnitude is never reported as negative.
                        out_sign_r <= neg & (bcd_next != '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Every output is a decode of state or a direct copy of a register.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign out_sign  = out_sign_r;
    assign out_bcd   = out_bcd_r;

endmodule

// File: doc/a2_bcd_conv.md
Name: a2_bcd_conv

Overview:
- Sequential converter from a DW-bit input word to sign + packed BCD magnitude, using iterative double-dabble (shift-add-3), one bit per clock.
- Per-conversion mode: two's complement or unsigned input.
- Sits between datapath results and the 7-segment display drivers.
- Valid/ready handshake on both sides. One conversion in flight at a time.

Parameters:
- DW, 8: input word width. Must be at least 2. The sign bit is bit DW-1, never a fixed index.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS >= 2^DW, checked by an elaboration-time assertion.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word presented.
- in_ready  out  1  converter can accept a word.
- in_data  in  DW  word to convert.
- in_signed  in  1  1: in_data is two's complement; 0: unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sign  out  1  1 = negative result.
- out_bcd  out  4*DIGITS  packed BCD magnitude; digit 0 (units) in bits [3:0].
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; in_ready=1; out_valid=0; busy=0; out_sign=0; out_bcd=0; internal shift, magnitude and counter registers cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a rising edge, capture the word: neg = in_signed & in_data[DW-1]; mag = neg ? (~in_data + 1) : in_data, as a DW-bit unsigned value.
  - Clear the BCD accumulator, load bit counter with DW, go to SHIFT.
  - in_signed is sampled only at this accept edge.
- Most-negative input (in_signed=1, in_data = 1 followed by zeros): the DW-bit negation yields 2^(DW-1), which is a correct unsigned magnitude. No saturation, no error flag.
- SHIFT, each cycle:
  - Every BCD digit >= 5 gets +3 (all digits in parallel, combinationally).
  - Then shift {bcd, mag} left by one; mag MSB enters bit 0 of the BCD.
  - Decrement the counter. When the counter reaches 1 on this edge, go to DONE.
  - Exactly DW cycles are spent in SHIFT. in_ready=0.
- DONE:
  - out_valid=1. out_bcd and out_sign are driven from registers and stay stable until the handshake.
  - When out_ready=1 at an edge, go to IDLE; out_valid drops after that edge.
- Zero magnitude always reports out_sign=0 (there is no negative zero).
- Latency: accept at edge N gives out_valid high after edge N+DW. Minimum issue interval is DW+2 cycles with out_ready held at 1.
- in_ready is high only in IDLE. in_valid outside IDLE is ignored and nothing is queued.
- out_bcd/out_sign hold the last result after leaving DONE. They are updated only at the SHIFT→DONE transition.
- Backpressure: DONE is held indefinitely while out_ready=0.
- Reset mid-operation (any state): the conversion is aborted, all outputs return to reset values immediately, and no out_valid is ever produced for the aborted word.
- Arithmetic: add-3 operates per 4-bit digit and never carries across digits. All widths are derived from DW and DIGITS.

Test Plan:
- DW=8, DIGITS=3, in_signed=1, in_data=8'hF6, accept at edge N → out_valid after edge N+8, out_sign=1, out_bcd=12'h010, busy=1 from N+1 until release.
- in_signed=1, in_data=8'h80 → out_sign=1, out_bcd=12'h128. Then in_data=8'h7F → sign 0, 12'h127. Then in_data=8'h00 → sign 0, 12'h000.
- in_signed=0, in_data=8'hFF → out_sign=0, out_bcd=12'h255. Same data with in_signed=1 → sign 1, 12'h001.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 with new data → outputs stable, in_ready=0, new word not accepted. Raise out_ready → IDLE next cycle, then next word accepted.
- Assert rst_n=0 mid-SHIFT at cycle 4 of 8 → out_valid/busy/out_bcd/out_sign go to 0 asynchronously. After release, a fresh word (8'h2A unsigned) yields 12'h042 with no stale result.
- DW=12, DIGITS=4 instance: in_signed=1, in_data=12'h800 → sign 1, out_bcd=16'h2048, out_valid 12 cycles after accept.
